toy_sa_drain: RTL
=================

# toy_sa_drain

Result-drain buffer on the systolic-array side of the vector datapath. Captures one tile of result rows from the array, then hands them out one row per shift request on the `sa_din`/`sa_shift_en` interface consumed by the vector ALU. It is the supplier end of that interface: the vector ALU pulls rows with `sa_shift_en`; this block answers with the next row on `sa_din`.

## Interface

Parameters:
- `DEPTH`, 8, maximum rows per tile; power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH+1)`, row-count width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous abort; empties the buffer and returns to IDLE.
- `sa_row_vld`  in  1  array result row valid.
- `sa_row_data`  in  `V_REG_WIDTH`  array result row.
- `sa_row_last`  in  1  marks the final row of the tile.
- `sa_row_rdy`  out  1  buffer accepts a row.
- `sa_shift_en`  in  1  consumer pops the head row.
- `sa_din`  out  `V_REG_WIDTH`  head row; zero when not valid.
- `sa_dout_vld`  out  1  `sa_din` holds a valid row.
- `sa_rows`  out  `CNT_W`  rows currently held.
- `drain_done`  out  1  one-cycle pulse, tile fully drained.
- `shift_uflow`  out  1  one-cycle pulse, `sa_shift_en` with no valid row.

## Operation

- FSM states: IDLE, FILL, DRAIN.
- IDLE: `sa_row_rdy`=1. An accepted row (`vld && rdy`) writes entry 0.
  - If the row carries `last`, or `DEPTH`==1 is reached, go to DRAIN.
  - Otherwise go to FILL.
- FILL: `sa_row_rdy`=1. Each accepted row writes at `wr_ptr` and increments it. Go to DRAIN on an accepted row with `last`, or when the accepted row makes `sa_rows`==`DEPTH`.
- DRAIN: `sa_row_rdy`=0 and `sa_dout_vld`=1.
  - `sa_din` = entry[`rd_ptr`].
  - `sa_shift_en` increments `rd_ptr` and decrements `sa_rows`.
  - The pop that takes `sa_rows` from 1 to 0 returns the FSM to IDLE, resets both pointers and registers `drain_done`.
- Rows are never exposed during FILL. `sa_dout_vld`=0 and `sa_din`=0 in IDLE and FILL.
- `sa_shift_en` outside DRAIN is ignored: no state change, `shift_uflow` pulses. `sa_row_vld` while `rdy`=0 is not accepted. The producer holds the row, per the valid/ready rule.
- `flush` has priority over push and pop in the same cycle. It clears pointers and count and goes to IDLE. It pulses neither `drain_done` nor `shift_uflow`.
- Storage contents are not reset. Only pointers, count, FSM and pulse registers are reset.

## Timing

- Reset values: `sa_row_rdy`=1 (IDLE), `sa_dout_vld`=0, `sa_din`=0, `sa_rows`=0, `drain_done`=0, `shift_uflow`=0.
- Push latency: a row accepted at cycle t is counted in `sa_rows` at t+1.
- Tile exposure: when the closing row is accepted at t, `sa_dout_vld`=1 and `sa_din`=row 0 from t+1.
- Pop: `sa_shift_en` at t gives `sa_din`=next row at t+1. Back-to-back pops drain one row per cycle.
- Final pop at t: at t+1 the FSM is IDLE, `sa_dout_vld`=0, `sa_din`=0, `drain_done`=1 for one cycle, and `sa_row_rdy`=1. A new row may be accepted at t+1.
- `sa_din` is combinational from storage, indexed by the registered `rd_ptr` and gated by the registered `sa_dout_vld`. There is no combinational path from `sa_shift_en` to `sa_din`.
- `shift_uflow` is registered: an illegal shift at t pulses it at t+1.
- Asserting `rst_n` low mid-tile immediately forces all reset values. The partial tile is lost.

## Structure

- Package `toy_vpack`: `V_REG_WIDTH`, and a new enum `sa_drain_state_e` {IDLE, FILL, DRAIN}.
- One sub-module: `toy_sa_row_buf`. It is a `DEPTH` × `V_REG_WIDTH` register array with a write port (en, idx, data) and an asynchronous read port (idx).
- The FSM, pointers and count are in `toy_sa_drain`.

## Test plan

- 4-row tile: rows 0x11..0x44, last on row 3 → `sa_dout_vld` rises 1 cycle after row 3. Four consecutive shifts yield 0x11, 0x22, 0x33, 0x44. `drain_done` pulses 1 cycle after the 4th shift. `sa_rows` goes 4→0.
- Full tile: 8 rows without `last` → DRAIN entered after row 8, `sa_row_rdy`=0 while a 9th row is held valid. The 9th row is accepted 1 cycle after the final pop.
- Single-row tile with `last` on row 0 → `sa_din` = that row next cycle. One shift → IDLE plus `drain_done`.
- Shift in IDLE and in FILL → `shift_uflow` pulses each time, `sa_rows` is unchanged, no pop.
- `flush` during DRAIN with 3 rows left, concurrent with `sa_shift_en` → next cycle IDLE, `sa_rows`=0, `sa_din`=0, no `drain_done`.
- `rst_n` low mid-FILL (2 rows held) → all outputs take reset values asynchronously. A following 1-row tile drains correctly.

Source files
------------

// File: rtl/toy_sa_drain_pkg.sv
// Shared vector-datapath definitions: register width and the result-drain FSM states.
package toy_vpack;

  localparam int unsigned V_REG_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } sa_drain_state_e;

endpackage

// File: rtl/toy_sa_drain_row_buf.sv
// Row storage for one result tile: single write port, asynchronous read port.
module toy_sa_row_buf
  import toy_vpack::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic [IDX_W-1:0]       i_wr_idx,
  input  logic [V_REG_WIDTH-1:0] i_wr_data,
  input  logic [IDX_W-1:0]       i_rd_idx,
  output logic [V_REG_WIDTH-1:0] o_rd_data
);

  logic [V_REG_WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately left unreset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/toy_sa_drain.sv
// Captures one tile of systolic-array result rows, then supplies them one row
// per sa_shift_en to the vector ALU.
module toy_sa_drain
  import toy_vpack::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   sa_row_vld,
  input  logic [V_REG_WIDTH-1:0] sa_row_data,
  input  logic                   sa_row_last,
  output logic                   sa_row_rdy,
  input  logic                   sa_shift_en,
  output logic [V_REG_WIDTH-1:0] sa_din,
  output logic                   sa_dout_vld,
  output logic [CNT_W-1:0]       sa_rows,
  output logic                   drain_done,
  output logic                   shift_uflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  sa_drain_state_e        r_state, w_state_nxt;
  logic [PTR_W-1:0]       r_wr_ptr, w_wr_ptr_nxt;
  logic [PTR_W-1:0]       r_rd_ptr, w_rd_ptr_nxt;
  logic [CNT_W-1:0]       r_rows, w_rows_nxt;
  logic                   r_drain_done, w_drain_done_nxt;
  logic                   r_shift_uflow, w_shift_uflow_nxt;
  logic                   w_push;
  logic                   w_pop;
  logic [V_REG_WIDTH-1:0] w_rd_data;

  assign sa_row_rdy  = (r_state != DRAIN);
  assign sa_dout_vld = (r_state == DRAIN);
  assign sa_din      = sa_dout_vld ? w_rd_data : '0;
  assign sa_rows     = r_rows;
  assign drain_done  = r_drain_done;
  assign shift_uflow = r_shift_uflow;

  assign w_push = sa_row_vld && sa_row_rdy && !flush;
  assign w_pop  = sa_shift_en && (r_state == DRAIN) && !flush;

  toy_sa_row_buf #(
    .DEPTH (DEPTH),
    .IDX_W (PTR_W)
  ) u_row_buf (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_idx  (r_wr_ptr),
    .i_wr_data (sa_row_data),
    .i_rd_idx  (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rows        <= '0;
      r_drain_done  <= 1'b0;
      r_shift_uflow <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_rows        <= w_rows_nxt;
      r_drain_done  <= w_drain_done_nxt;
      r_shift_uflow <= w_shift_uflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_rows_nxt        = r_rows;
    w_drain_done_nxt  = 1'b0;
    w_shift_uflow_nxt = 1'b0;

    if (flush) begin
      w_state_nxt  = IDLE;
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_rows_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE, FILL: begin
          w_shift_uflow_nxt = sa_shift_en;
          if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            w_rows_nxt   = r_rows + CNT_W'(1);
            if (sa_row_last || (w_rows_nxt == CNT_W'(DEPTH))) begin
              w_state_nxt = DRAIN;
            end else begin
              w_state_nxt = FILL;
            end
          end
        end
        DRAIN: begin
          if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            w_rows_nxt   = r_rows - CNT_W'(1);
            if (r_rows == CNT_W'(1)) begin
              w_state_nxt      = IDLE;
              w_wr_ptr_nxt     = '0;
              w_rd_ptr_nxt     = '0;
              w_drain_done_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule
